// File: rtl/ppc_mdu_pkg.sv
// rtl/ppc_mdu_pkg.sv - op encodings, state enum and iteration count for the iterative MDU
package ppc_mdu_pkg;

   localparam logic [2:0] MDU_MULLW  = 3'd0;
   localparam logic [2:0] MDU_MULHW  = 3'd1;
   localparam logic [2:0] MDU_MULHWU = 3'd2;
   localparam logic [2:0] MDU_DIVW   = 3'd3;
   localparam logic [2:0] MDU_DIVWU  = 3'd4;

   localparam int MDU_ITER = 32;

   typedef enum logic [1:0] {
      MDU_IDLE = 2'd0,
      MDU_CALC = 2'd1,
      MDU_FIX  = 2'd2
   } mdu_state_t;

endpackage

// File: rtl/ppc_mdu.sv
// rtl/ppc_mdu.sv - iterative 32-bit multiply/divide unit with shared shift/add datapath
module ppc_mdu
   import ppc_mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             flush,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             ov
);

   localparam int W = WIDTH;

   mdu_state_t       state;
   logic [4:0]       cnt;
   logic [2:0]       op_q;
   logic             div_q;
   logic             neg_q;
   logic             spec_q;
   logic             spec_ov_q;
   logic [W-1:0]     opnd;
   logic [2*W-1:0]   acc;

   logic             signed_op;
   logic             is_div;
   logic             illegal;
   logic             div_zero;
   logic             div_ovf;
   logic [W-1:0]     a_mag;
   logic [W-1:0]     b_mag;

   logic [W+1:0]     add_x;
   logic [W+1:0]     add_y;
   logic [W+1:0]     add_s;
   logic [2*W-1:0]   acc_next;
   logic [2*W-1:0]   prod;
   logic [W-1:0]     quot;
   logic [W-1:0]     fix_val;

   always_comb begin
      signed_op = (op == MDU_MULLW) || (op == MDU_MULHW) || (op == MDU_DIVW);
      is_div    = (op == MDU_DIVW) || (op == MDU_DIVWU);
      illegal   = (op > MDU_DIVWU);
      div_zero  = is_div && (b == '0);
      div_ovf   = (op == MDU_DIVW) && (a == {1'b1, {(W-1){1'b0}}}) && (b == '1);
      a_mag     = (signed_op && a[W-1]) ? (~a + 1'b1) : a;
      b_mag     = (signed_op && b[W-1]) ? (~b + 1'b1) : b;
   end

   // One adder serves both ops: add-if-lsb for multiply, trial subtract for divide.
   always_comb begin
      if (div_q) begin
         add_x = {1'b0, acc[2*W-1:W-1]};
         add_y = ~{2'b00, opnd};
      end else begin
         add_x = {2'b00, acc[2*W-1:W]};
         add_y = acc[0] ? {2'b00, opnd} : '0;
      end
      add_s = add_x + add_y + {{(W+1){1'b0}}, div_q};

      if (div_q) begin
         if (!add_s[W+1])
            acc_next = {add_s[W-1:0], acc[W-2:0], 1'b1};
         else
            acc_next = {acc[2*W-2:0], 1'b0};
      end else begin
         acc_next = {add_s[W:0], acc[W-1:1]};
      end
   end

   always_comb begin
      prod = neg_q ? (~acc + 1'b1) : acc;
      quot = neg_q ? (~acc[W-1:0] + 1'b1) : acc[W-1:0];
      if (div_q)
         fix_val = quot;
      else if (op_q == MDU_MULLW)
         fix_val = prod[W-1:0];
      else
         fix_val = prod[2*W-1:W];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= MDU_IDLE;
         cnt       <= '0;
         op_q      <= '0;
         div_q     <= 1'b0;
         neg_q     <= 1'b0;
         spec_q    <= 1'b0;
         spec_ov_q <= 1'b0;
         opnd      <= '0;
         acc       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         result    <= '0;
         ov        <= 1'b0;
      end else if (flush) begin
         state <= MDU_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            MDU_IDLE: begin
               if (start) begin
                  op_q  <= op;
                  busy  <= 1'b1;
                  cnt   <= '0;
                  div_q <= is_div;
                  neg_q <= signed_op && (a[W-1] ^ b[W-1]);
                  opnd  <= is_div ? b_mag : a_mag;
                  acc   <= {{W{1'b0}}, (is_div ? a_mag : b_mag)};
                  if (illegal || div_zero || div_ovf) begin
                     spec_q    <= 1'b1;
                     spec_ov_q <= div_zero || div_ovf;
                     state     <= MDU_FIX;
                  end else begin
                     spec_q    <= 1'b0;
                     spec_ov_q <= 1'b0;
                     state     <= MDU_CALC;
                  end
               end
            end
            MDU_CALC: begin
               acc <= acc_next;
               cnt <= cnt + 5'd1;
               if (cnt == 5'(MDU_ITER - 1))
                  state <= MDU_FIX;
            end
            MDU_FIX: begin
               result <= spec_q ? '0 : fix_val;
               ov     <= spec_q ? spec_ov_q : 1'b0;
               done   <= 1'b1;
               busy   <= 1'b0;
               state  <= MDU_IDLE;
            end
            default: begin
               state <= MDU_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ppc_mdu.sv
// tb/tb_ppc_mdu.sv - table-driven and sequence checks for ppc_mdu
module tb_ppc_mdu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        flush;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        ov;

   int errors = 0;
   int checks = 0;

   ppc_mdu #(.WIDTH(32)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .flush  (flush),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .ov     (ov)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        ov;
      int          lat;
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Called at #1 after an edge; returns edges waited until done is seen.
   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 60) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic launch(input logic [2:0] o, input logic [31:0] xa, input logic [31:0] xb);
      start = 1'b1;
      op    = o;
      a     = xa;
      b     = xb;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic run_vec(input string nm, input vec_t v);
      int n;
      launch(v.op, v.a, v.b);
      chk({nm, "_busy"}, 32'(busy), 32'd1);
      wait_done(n);
      chk({nm, "_lat"}, 32'(n), 32'(v.lat));
      chk({nm, "_res"}, result, v.res);
      chk({nm, "_ov"}, 32'(ov), 32'(v.ov));
      chk({nm, "_busy_done"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int n;
      int seen;
      logic [31:0] prev;

      vecs[0]  = '{3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, 1'b0, 33};
      vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 33};
      vecs[2]  = '{3'd2, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 33};
      vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33};
      vecs[4]  = '{3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, 33};
      vecs[5]  = '{3'd4, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 1'b0, 33};
      vecs[6]  = '{3'd4, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b1, 1};
      vecs[7]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1};
      vecs[8]  = '{3'd7, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 1'b0, 1};
      vecs[9]  = '{3'd1, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 33};
      vecs[10] = '{3'd0, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 1'b0, 33};
      vecs[11] = '{3'd3, 32'h0000_0064, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0, 33};
      vecs[12] = '{3'd3, 32'hFFFF_FFF8, 32'hFFFF_FFFE, 32'h0000_0004, 1'b0, 33};
      vecs[13] = '{3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 1'b0, 33};
      vecs[14] = '{3'd4, 32'h0000_0007, 32'h0000_0009, 32'h0000_0000, 1'b0, 33};

      rst_n = 1'b0;
      start = 1'b0;
      flush = 1'b0;
      op    = '0;
      a     = '0;
      b     = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_ov", 32'(ov), 32'd0);

      // Consecutive vectors start in the done cycle of the previous one.
      for (int i = 0; i < 15; i++)
         run_vec($sformatf("vec%0d", i), vecs[i]);

      // Flush mid-divide.
      prev = result;
      launch(3'd4, 32'd100, 32'd3);
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      chk("flush_busy", 32'(busy), 32'd0);
      chk("flush_done", 32'(done), 32'd0);
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done) seen++;
      end
      chk("flush_no_done", 32'(seen), 32'd0);
      chk("flush_result_kept", result, prev);
      run_vec("after_flush", '{3'd4, 32'd100, 32'd3, 32'd33, 1'b0, 33});

      // Flush and start together: start is dropped.
      start = 1'b1;
      flush = 1'b1;
      op = 3'd0; a = 32'd2; b = 32'd2;
      @(posedge clk);
      #1;
      start = 1'b0;
      flush = 1'b0;
      chk("flush_start_busy", 32'(busy), 32'd0);
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done) seen++;
      end
      chk("flush_start_no_done", 32'(seen), 32'd0);

      // Flush during the FIX cycle.
      prev = result;
      launch(3'd4, 32'd1000, 32'd10);
      repeat (32) @(posedge clk);
      #1;
      chk("fix_busy", 32'(busy), 32'd1);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      chk("fix_flush_done", 32'(done), 32'd0);
      chk("fix_flush_busy", 32'(busy), 32'd0);
      chk("fix_flush_result", result, prev);

      // Start while busy is ignored.
      launch(3'd0, 32'd3, 32'd5);
      repeat (4) @(posedge clk);
      #1;
      start = 1'b1;
      op = 3'd4; a = 32'd50; b = 32'd0;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(n);
      chk("ignore_lat", 32'(n + 5), 32'd33);
      chk("ignore_res", result, 32'd15);
      chk("ignore_ov", 32'(ov), 32'd0);

      // Reset mid-operation.
      launch(3'd0, 32'd7, 32'd9);
      repeat (19) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_result", result, 32'd0);
      chk("midrst_ov", 32'(ov), 32'd0);
      run_vec("after_rst", '{3'd0, 32'd7, 32'd9, 32'd63, 1'b0, 33});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
